// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring-oscillator blocks: meter FSM states and parameter defaults.
// Latency: none (package only).
// Backpressure: none (package only).
package ring_osc_pkg;

    // Default widths for the frequency meter; other oscillator-control blocks
    // pick these up so the whole cluster agrees on result widths.
    localparam int GATE_BITS_DEF   = 16;
    localparam int COUNT_BITS_DEF  = 12;
    localparam int SYNC_STAGES_DEF = 2;

    // Measurement FSM: idle waiting for start, or counting inside a window.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } meter_state_t;

endpackage : ring_osc_pkg

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for bringing an asynchronous level into the clk domain.
// Latency: STAGES clk cycles from first capture to q (plus metastability resolution).
// Backpressure: none; free-running, samples d every cycle.
//
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, all stages cleared to 0
//   d   - asynchronous input level
//   q   - synchronized level (last stage)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift register: bit 0 is the capture flop that may go metastable,
    // later bits give it time to resolve before anyone looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of osc_in over a window of gate_len clk cycles.
// Latency: result (count/overflow/count_valid) visible max(gate_len,1)+1 cycles after start.
// Backpressure: none; count_valid is a one-cycle pulse, the consumer must take it when it fires.
//
// Ports:
//   clk         - system clock, only clock in the block
//   rst         - asynchronous active-high reset
//   osc_in      - divided ring-oscillator output, asynchronous to clk
//   start       - begin a measurement, looked at only while idle
//   continuous  - chain windows back to back with no dead cycle
//   gate_len    - window length in clk cycles (0 behaves as 1)
//   busy        - high while a window is being counted
//   count       - edge count of the last completed window (held)
//   count_valid - one-cycle pulse when count/overflow update
//   overflow    - last completed window saturated count
module ring_osc_freq_meter
    import ring_osc_pkg::*;
#(
    parameter int GATE_BITS   = GATE_BITS_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [GATE_BITS-1:0]  gate_len,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] count,
    output logic                  count_valid,
    output logic                  overflow
);

    meter_state_t state, state_nxt;

    logic                  osc_sync;
    logic                  osc_hist;
    logic                  osc_edge;

    logic [GATE_BITS-1:0]  win_cnt;
    logic [COUNT_BITS-1:0] edge_cnt;
    logic                  ovf_acc;

    logic [GATE_BITS-1:0]  gate_eff;
    logic                  last_cycle;
    logic                  cnt_at_max;
    logic [COUNT_BITS-1:0] edge_cnt_upd;
    logic                  ovf_upd;

    logic                  do_load;
    logic                  do_finish;

    // ------------------------------------------------------------------
    // Input synchronizer and rising-edge detect. Runs in every state so
    // the history flop already tracks osc_in when a window opens; a level
    // that was high before start is not mistaken for a fresh edge.
    // ------------------------------------------------------------------
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_osc_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_in),
        .q   (osc_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osc_hist <= 1'b0;
        end else begin
            osc_hist <= osc_sync;
        end
    end

    assign osc_edge = osc_sync & ~osc_hist;

    // ------------------------------------------------------------------
    // Window and accumulator arithmetic
    // ------------------------------------------------------------------
    assign gate_eff   = (gate_len == '0) ? GATE_BITS'(1) : gate_len;
    assign last_cycle = (win_cnt == GATE_BITS'(1));
    assign cnt_at_max = &edge_cnt;

    // Saturating count including this cycle's edge; an edge that arrives
    // with the counter already pinned is what flags overflow.
    assign edge_cnt_upd = (osc_edge && !cnt_at_max) ? edge_cnt + COUNT_BITS'(1) : edge_cnt;
    assign ovf_upd      = ovf_acc | (osc_edge & cnt_at_max);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        do_load   = 1'b0;
        do_finish = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    do_load   = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                busy = 1'b1;
                if (last_cycle) begin
                    do_finish = 1'b1;
                    // Reloading on the last cycle keeps continuous windows
                    // gap-free: the next window's first sample is the very
                    // next cycle.
                    if (continuous) begin
                        do_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Window counter, accumulators and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt     <= '0;
            edge_cnt    <= '0;
            ovf_acc     <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;

            if (do_finish) begin
                count       <= edge_cnt_upd;
                overflow    <= ovf_upd;
                count_valid <= 1'b1;
            end

            if (do_load) begin
                win_cnt  <= gate_eff;
                edge_cnt <= '0;
                ovf_acc  <= 1'b0;
            end else if (state == COUNT) begin
                win_cnt  <= win_cnt - GATE_BITS'(1);
                edge_cnt <= edge_cnt_upd;
                ovf_acc  <= ovf_upd;
            end
        end
    end

endmodule : ring_osc_freq_meter
